// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin write arbiter: FSM state encoding and index-width helper.
package reg_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Client-side bus of the shared register arbiter: requests and packed write data in, grant and register state out.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned IDX_W = clog2_safe(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       ack;
    logic [IDX_W-1:0]       owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       qbar;

    modport master (
        output req, wdata,
        input  ack, owner, busy, q, qbar
    );

    modport slave (
        input  req, wdata,
        output ack, owner, busy, q, qbar
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping at N_REQ-1.
module rr_priority_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = clog2_safe(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid_c,
    output logic [IDX_W-1:0] o_index_c,
    output logic [N_REQ-1:0] o_onehot_c
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_valid_c  = 1'b0;
        o_index_c  = '0;
        o_onehot_c = '0;
        w_idx      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            w_idx = IDX_W'((32'(i_ptr) + off) % N_REQ);
            if (!o_valid_c && i_req[w_idx]) begin
                o_valid_c = 1'b1;
                o_index_c = w_idx;
            end
        end
        if (o_valid_c) begin
            o_onehot_c = N_REQ'(1) << o_index_c;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that is the sole writer of a shared q/qbar register, with a post-write hold window.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_write_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = clog2_safe(N_REQ);
    localparam int unsigned CNT_W = clog2_safe(HOLD_CYCLES + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [N_REQ-1:0] r_ack;
    logic             r_busy;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;

    logic             w_valid_c;
    logic [IDX_W-1:0] w_index_c;
    logic [N_REQ-1:0] w_onehot_c;
    logic [WIDTH-1:0] w_wdata_sel;
    logic [IDX_W-1:0] w_ptr_next;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_valid_c  (w_valid_c),
        .o_index_c  (w_index_c),
        .o_onehot_c (w_onehot_c)
    );

    // Data mux for the winning requester's slice.
    always_comb begin
        w_wdata_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_index_c == IDX_W'(i)) begin
                w_wdata_sel = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_index_c == IDX_W'(N_REQ - 1)) ? '0 : w_index_c + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
            r_qbar  <= '1;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid_c) begin
                        r_q     <= w_wdata_sel;
                        r_qbar  <= ~w_wdata_sel;
                        r_ack   <= w_onehot_c;
                        r_owner <= w_index_c;
                        r_ptr   <= w_ptr_next;
                        if (HOLD_CYCLES > 0) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= CNT_W'(HOLD_CYCLES);
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Requests are ignored until the counter expires.
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack   = r_ack;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.q     = r_q;
    assign bus.qbar  = r_qbar;

endmodule
